seq_loop_monitor: RTL and testbench

- Consumer stage of the sequential-loop monitor interface in the co-simulation bench.
- Watches the DUT FSM `cur_state` against the loop's pre, post, quit and iteration-end state sets, and derives loop entry/exit and iteration events.
- Accumulates iteration and loop counts and raises a per-iteration watchdog.
- Results feed the bench scoreboard and the trip-count report. Synthesizable RTL; one clock domain.

---
 rtl/seq_loop_monitor_pkg.sv | 11 +
 rtl/seq_loop_state_match.sv | 29 ++
 rtl/seq_loop_monitor.sv | 135 +++++++++++++
 tb/tb_seq_loop_monitor.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_loop_monitor_pkg.sv
// seq_loop_monitor_pkg: shared state encoding and saturating-increment helper
package seq_loop_monitor_pkg;
  typedef enum logic [1:0] {IDLE, IN_LOOP, DONE} mon_state_t;
  localparam int unsigned SAT_MAX_W = 64;
  // Width-generic saturating increment: callers widen to SAT_MAX_W, pass their width, and truncate back.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v, input int unsigned w);
    logic [SAT_MAX_W-1:0] m;
    m = (w >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << w) - SAT_MAX_W'(1));
    return (v >= m) ? m : v + SAT_MAX_W'(1);
  endfunction
endpackage

// File: rtl/seq_loop_state_match.sv
// seq_loop_state_match: combinational start/end/quit state-set matching
module seq_loop_state_match
  import seq_loop_monitor_pkg::*;
#(
  parameter int unsigned FSM_WIDTH = 2
) (
  input  logic [FSM_WIDTH-1:0] cur_state_i,
  input  logic                 quit_states_valid_i,
  input  logic [FSM_WIDTH-1:0] quit_loop_state0_i,
  input  logic [FSM_WIDTH-1:0] loop_quit_state_i,
  input  logic [FSM_WIDTH-1:0] iter_start_state_i,
  input  logic [1:0]           iter_end_states_valid_i,
  input  logic [FSM_WIDTH-1:0] iter_end_state0_i,
  input  logic [FSM_WIDTH-1:0] iter_end_state1_i,
  input  logic                 one_state_loop_i,
  output logic                 start_hit_o,
  output logic                 end_hit_o,
  output logic                 quit_hit_o
);
  // In a single-state loop every visit to the start state also completes an iteration.
  always_comb begin
    start_hit_o = (cur_state_i == iter_start_state_i);
    end_hit_o   = one_state_loop_i ? start_hit_o :
                  (iter_end_states_valid_i[0] && cur_state_i == iter_end_state0_i) ||
                  (iter_end_states_valid_i[1] && cur_state_i == iter_end_state1_i);
    quit_hit_o  = (quit_states_valid_i && cur_state_i == quit_loop_state0_i) ||
                  (cur_state_i == loop_quit_state_i);
  end
endmodule

// File: rtl/seq_loop_monitor.sv
// seq_loop_monitor: loop entry/exit/iteration tracker with counters and watchdog (optional SEQ_LOOP_MONITOR_CYCLE_CNT_EN cycle counter)
module seq_loop_monitor
  import seq_loop_monitor_pkg::*;
#(
  parameter int unsigned FSM_WIDTH      = 2,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [FSM_WIDTH-1:0] cur_state,
  input  logic                 quit_states_valid,
  input  logic [FSM_WIDTH-1:0] quit_loop_state0,
  input  logic [FSM_WIDTH-1:0] loop_quit_state,
  input  logic [FSM_WIDTH-1:0] iter_start_state,
  input  logic [1:0]           iter_end_states_valid,
  input  logic [FSM_WIDTH-1:0] iter_end_state0,
  input  logic [FSM_WIDTH-1:0] iter_end_state1,
  input  logic                 one_state_loop,
  input  logic                 finish,
  output logic                 loop_active,
  output logic                 loop_entry,
  output logic                 loop_exit,
  output logic                 iter_done,
  output logic [CNT_WIDTH-1:0] iter_count,
  output logic [CNT_WIDTH-1:0] last_trip_count,
  output logic [CNT_WIDTH-1:0] loop_count,
  output logic                 timeout,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] loop_cycles
);
  mon_state_t           state_q;
  logic                 start_hit, end_hit, quit_hit;
  logic                 entry_q, exit_q, iter_done_q, timeout_q, done_q;
  logic [CNT_WIDTH-1:0] iter_q, last_trip_q, loop_cnt_q, wd_q;
  logic [CNT_WIDTH-1:0] iter_inc, loop_inc, wd_inc, trip_d;
  logic                 wd_expire;

  seq_loop_state_match #(.FSM_WIDTH(FSM_WIDTH)) u_match (
    .cur_state_i            (cur_state),
    .quit_states_valid_i    (quit_states_valid),
    .quit_loop_state0_i     (quit_loop_state0),
    .loop_quit_state_i      (loop_quit_state),
    .iter_start_state_i     (iter_start_state),
    .iter_end_states_valid_i(iter_end_states_valid),
    .iter_end_state0_i      (iter_end_state0),
    .iter_end_state1_i      (iter_end_state1),
    .one_state_loop_i       (one_state_loop),
    .start_hit_o            (start_hit),
    .end_hit_o              (end_hit),
    .quit_hit_o             (quit_hit)
  );

  // Saturated increments; trip_d is the trip count including an iteration that ends on the exit cycle.
  always_comb begin
    iter_inc  = CNT_WIDTH'(sat_inc(SAT_MAX_W'(iter_q), CNT_WIDTH));
    loop_inc  = CNT_WIDTH'(sat_inc(SAT_MAX_W'(loop_cnt_q), CNT_WIDTH));
    wd_inc    = CNT_WIDTH'(sat_inc(SAT_MAX_W'(wd_q), CNT_WIDTH));
    wd_expire = SAT_MAX_W'(wd_inc) >= SAT_MAX_W'(TIMEOUT_CYCLES);
    trip_d    = end_hit ? iter_inc : iter_q;
  end

  // Loop FSM with registered pulses/counters; finish overrides the next state after the cycle's events.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      entry_q     <= 1'b0;
      exit_q      <= 1'b0;
      iter_done_q <= 1'b0;
      timeout_q   <= 1'b0;
      done_q      <= 1'b0;
      iter_q      <= '0;
      last_trip_q <= '0;
      loop_cnt_q  <= '0;
      wd_q        <= '0;
    end else begin
      entry_q     <= 1'b0;
      exit_q      <= 1'b0;
      iter_done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_hit) begin
          state_q     <= IN_LOOP;
          entry_q     <= 1'b1;
          iter_q      <= end_hit ? CNT_WIDTH'(1) : '0;
          iter_done_q <= end_hit;
          wd_q        <= '0;
        end
        IN_LOOP: begin
          if (end_hit) begin
            iter_q      <= iter_inc;
            iter_done_q <= 1'b1;
            wd_q        <= '0;
          end else begin
            wd_q <= wd_inc;
            if (wd_expire) timeout_q <= 1'b1;
          end
          if (quit_hit) begin
            state_q     <= IDLE;
            exit_q      <= 1'b1;
            loop_cnt_q  <= loop_inc;
            last_trip_q <= trip_d;
            wd_q        <= '0;
          end
        end
        default: ;
      endcase
      if (finish) begin
        state_q <= DONE;
        done_q  <= 1'b1;
      end
    end
  end

  assign loop_active     = (state_q == IN_LOOP);
  assign loop_entry      = entry_q;
  assign loop_exit       = exit_q;
  assign iter_done       = iter_done_q;
  assign iter_count      = iter_q;
  assign last_trip_count = last_trip_q;
  assign loop_count      = loop_cnt_q;
  assign timeout         = timeout_q;
  assign done            = done_q;

`ifdef SEQ_LOOP_MONITOR_CYCLE_CNT_EN
  logic [CNT_WIDTH-1:0] cyc_q;
  // Count every clock spent inside a loop; DONE is not IN_LOOP, so the count freezes there.
  always_ff @(posedge clock) begin
    if (reset) cyc_q <= '0;
    else if (state_q == IN_LOOP) cyc_q <= CNT_WIDTH'(sat_inc(SAT_MAX_W'(cyc_q), CNT_WIDTH));
  end
  assign loop_cycles = cyc_q;
`else
  assign loop_cycles = '0;
`endif
endmodule

// File: tb/tb_seq_loop_monitor.sv
// tb_seq_loop_monitor: table, directed and randomized checks of seq_loop_monitor
module tb_seq_loop_monitor;
  localparam int T_OUT = 8;
  logic        clock = 1'b0, reset = 1'b0, finish = 1'b0;
  logic [1:0]  cur_state = '0, quit_loop_state0 = '0, loop_quit_state = '0, iter_start_state = '0;
  logic [1:0]  iter_end_state0 = '0, iter_end_state1 = '0, iter_end_states_valid = '0;
  logic        quit_states_valid = 1'b0, one_state_loop = 1'b0;
  logic        loop_active, loop_entry, loop_exit, iter_done, timeout, done;
  logic [31:0] iter_count, last_trip_count, loop_count, loop_cycles;
  int n_vec = 0, n_err = 0;

  seq_loop_monitor #(.FSM_WIDTH(2), .CNT_WIDTH(32), .TIMEOUT_CYCLES(T_OUT)) dut (
    .clock(clock), .reset(reset), .cur_state(cur_state),
    .quit_states_valid(quit_states_valid), .quit_loop_state0(quit_loop_state0),
    .loop_quit_state(loop_quit_state), .iter_start_state(iter_start_state),
    .iter_end_states_valid(iter_end_states_valid), .iter_end_state0(iter_end_state0),
    .iter_end_state1(iter_end_state1), .one_state_loop(one_state_loop), .finish(finish),
    .loop_active(loop_active), .loop_entry(loop_entry), .loop_exit(loop_exit),
    .iter_done(iter_done), .iter_count(iter_count), .last_trip_count(last_trip_count),
    .loop_count(loop_count), .timeout(timeout), .done(done), .loop_cycles(loop_cycles)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit           rst;
    logic [1:0]   cur;
    logic [127:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [127:0] pk(bit a, bit en, bit ex, bit id, bit to, bit dn, int ic, int lt, int lc);
    return {26'd0, a, en, ex, id, to, dn, 32'(ic), 32'(lt), 32'(lc)};
  endfunction

  function automatic logic [127:0] obs();
    return {26'd0, loop_active, loop_entry, loop_exit, iter_done, timeout, done, iter_count, last_trip_count, loop_count};
  endfunction

  function automatic vec_t mk(bit rst, logic [1:0] cur, logic [127:0] exp);
    vec_t v;
    v.rst = rst; v.cur = cur; v.exp = exp;
    return v;
  endfunction

  task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(bit rst, bit fin, logic [1:0] cur);
    reset = rst; finish = fin; cur_state = cur;
    @(posedge clock);
    #1;
  endtask

  task automatic cfg(logic [1:0] st, logic [1:0] e0, logic [1:0] e1, logic [1:0] ev, logic [1:0] qs, bit qv, logic [1:0] q0, bit one);
    iter_start_state = st; iter_end_state0 = e0; iter_end_state1 = e1; iter_end_states_valid = ev;
    loop_quit_state = qs; quit_states_valid = qv; quit_loop_state0 = q0; one_state_loop = one;
  endtask

  // Reference model: loop mode 0 = outside, 1 = inside, 2 = finished; gap counts cycles since the last iteration event.
  int m_mode, m_iter, m_last, m_loops, m_gap, m_cyc;
  bit m_entry, m_exit, m_idone, m_to, m_done;

  task automatic model_reset();
    m_mode = 0; m_iter = 0; m_last = 0; m_loops = 0; m_gap = 0; m_cyc = 0;
    m_entry = 0; m_exit = 0; m_idone = 0; m_to = 0; m_done = 0;
  endtask

  task automatic model_step();
    logic [1:0] ends[2];
    bit s, e, q;
    ends[0] = iter_end_state0; ends[1] = iter_end_state1;
    s = (cur_state == iter_start_state);
    e = 0;
    foreach (ends[i]) if (iter_end_states_valid[i] && cur_state == ends[i]) e = 1;
    if (one_state_loop) e = s;
    q = (cur_state == loop_quit_state) || (quit_states_valid && cur_state == quit_loop_state0);
    if (reset) begin
      model_reset();
      return;
    end
    m_entry = 0; m_exit = 0; m_idone = 0;
    if (m_mode == 0 && s) begin
      m_mode = 1; m_entry = 1; m_iter = e ? 1 : 0; m_idone = e; m_gap = 0;
    end else if (m_mode == 1) begin
`ifdef SEQ_LOOP_MONITOR_CYCLE_CNT_EN
      m_cyc++;
`endif
      if (e) begin m_iter++; m_idone = 1; m_gap = 0; end
      else begin m_gap++; if (m_gap >= T_OUT) m_to = 1; end
      if (q) begin m_mode = 0; m_exit = 1; m_loops++; m_last = m_iter; m_gap = 0; end
    end
    if (finish) begin m_mode = 2; m_done = 1; end
  endtask

  initial begin
    int frozen_cyc;
    // Three-iteration loop, idle hold, then reset mid-loop and a fresh loop.
    cfg(2'd1, 2'd2, 2'd0, 2'b01, 2'd3, 1'b0, 2'd0, 1'b0);
    tbl.push_back(mk(1, 2'd0, pk(0,0,0,0,0,0,0,0,0)));
    tbl.push_back(mk(0, 2'd0, pk(0,0,0,0,0,0,0,0,0)));
    tbl.push_back(mk(0, 2'd1, pk(1,1,0,0,0,0,0,0,0)));
    tbl.push_back(mk(0, 2'd2, pk(1,0,0,1,0,0,1,0,0)));
    tbl.push_back(mk(0, 2'd1, pk(1,0,0,0,0,0,1,0,0)));
    tbl.push_back(mk(0, 2'd2, pk(1,0,0,1,0,0,2,0,0)));
    tbl.push_back(mk(0, 2'd1, pk(1,0,0,0,0,0,2,0,0)));
    tbl.push_back(mk(0, 2'd2, pk(1,0,0,1,0,0,3,0,0)));
    tbl.push_back(mk(0, 2'd3, pk(0,0,1,0,0,0,3,3,1)));
    tbl.push_back(mk(0, 2'd0, pk(0,0,0,0,0,0,3,3,1)));
    tbl.push_back(mk(0, 2'd1, pk(1,1,0,0,0,0,0,3,1)));
    tbl.push_back(mk(0, 2'd2, pk(1,0,0,1,0,0,1,3,1)));
    tbl.push_back(mk(0, 2'd1, pk(1,0,0,0,0,0,1,3,1)));
    tbl.push_back(mk(0, 2'd2, pk(1,0,0,1,0,0,2,3,1)));
    tbl.push_back(mk(1, 2'd2, pk(0,0,0,0,0,0,0,0,0)));
    tbl.push_back(mk(0, 2'd1, pk(1,1,0,0,0,0,0,0,0)));
    tbl.push_back(mk(0, 2'd2, pk(1,0,0,1,0,0,1,0,0)));
    tbl.push_back(mk(0, 2'd3, pk(0,0,1,0,0,0,1,1,1)));
    foreach (tbl[i]) begin
      drive(tbl[i].rst, 1'b0, tbl[i].cur);
      check($sformatf("table[%0d]", i), obs(), tbl[i].exp);
    end

    // Single-state loop: five visits to the start state, then quit.
    cfg(2'd1, 2'd2, 2'd0, 2'b01, 2'd3, 1'b0, 2'd0, 1'b1);
    drive(1, 0, 2'd0);
    drive(0, 0, 2'd1);
    check("one_state_first", obs(), pk(1,1,0,1,0,0,1,0,0));
    repeat (4) drive(0, 0, 2'd1);
    check("one_state_five", obs(), pk(1,0,0,1,0,0,5,0,0));
    drive(0, 0, 2'd3);
    check("one_state_exit", obs(), pk(0,0,1,0,0,0,5,5,1));

    // End state equals quit state: the final iteration is counted in the trip count.
    cfg(2'd1, 2'd2, 2'd0, 2'b01, 2'd2, 1'b0, 2'd0, 1'b0);
    drive(1, 0, 2'd0);
    drive(0, 0, 2'd1);
    drive(0, 0, 2'd2);
    check("coincident_end_quit", obs(), pk(0,0,1,1,0,0,1,1,1));

    // Watchdog; quit_loop_state0 = 0 is disabled so state 0 keeps the loop alive.
    cfg(2'd1, 2'd2, 2'd0, 2'b01, 2'd3, 1'b0, 2'd0, 1'b0);
    drive(1, 0, 2'd0);
    drive(0, 0, 2'd1);
    repeat (T_OUT - 1) drive(0, 0, 2'd0);
    check("wd_before", 128'(timeout), 128'(0));
    drive(0, 0, 2'd0);
    check("wd_fire", obs(), pk(1,0,0,0,1,0,0,0,0));
    drive(0, 0, 2'd3);
    check("wd_exit_sticky", obs(), pk(0,0,1,0,1,0,0,0,1));
    drive(0, 0, 2'd0);
    check("wd_idle_sticky", 128'(timeout), 128'(1));

    // Enabled quit_loop_state0 ends the loop.
    cfg(2'd1, 2'd2, 2'd0, 2'b01, 2'd3, 1'b1, 2'd0, 1'b0);
    drive(1, 0, 2'd3);
    drive(0, 0, 2'd1);
    drive(0, 0, 2'd2);
    drive(0, 0, 2'd0);
    check("quit_state0", obs(), pk(0,0,1,0,0,0,1,1,1));

    // finish inside a loop freezes everything.
    cfg(2'd1, 2'd2, 2'd0, 2'b01, 2'd3, 1'b0, 2'd0, 1'b0);
    drive(1, 0, 2'd0);
    drive(0, 0, 2'd1);
    drive(0, 0, 2'd2);
    drive(0, 0, 2'd1);
    drive(0, 1, 2'd0);
    check("finish_enter", obs(), pk(0,0,0,0,0,1,1,0,0));
`ifdef SEQ_LOOP_MONITOR_CYCLE_CNT_EN
    frozen_cyc = 3;
`else
    frozen_cyc = 0;
`endif
    check("finish_cycles", 128'(loop_cycles), 128'(frozen_cyc));
    drive(0, 0, 2'd1);
    drive(0, 0, 2'd2);
    drive(0, 0, 2'd1);
    drive(0, 0, 2'd3);
    check("finish_frozen", obs(), pk(0,0,0,0,0,1,1,0,0));
    check("finish_cycles_frozen", 128'(loop_cycles), 128'(frozen_cyc));

    // finish together with quit: exit is recorded, then DONE.
    drive(1, 0, 2'd0);
    drive(0, 0, 2'd1);
    drive(0, 0, 2'd2);
    drive(0, 1, 2'd3);
    check("finish_with_quit", obs(), pk(0,0,1,0,0,1,1,1,1));

    // Randomized run against the reference model.
    drive(1, 0, 2'd0);
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0)
        cfg(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
            1'($urandom), 2'($urandom), ($urandom_range(0, 4) == 0));
      reset = ($urandom_range(0, 49) == 0);
      finish = ($urandom_range(0, 149) == 0);
      cur_state = ($urandom_range(0, 3) == 0) ? cur_state : 2'($urandom);
      model_step();
      @(posedge clock);
      #1;
      check($sformatf("rand[%0d]", c), obs(), pk(m_mode == 1, m_entry, m_exit, m_idone, m_to, m_done, m_iter, m_last, m_loops));
      check($sformatf("rand_cyc[%0d]", c), 128'(loop_cycles), 128'(m_cyc));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
